// File: rtl/uart_rx_sipo.sv
// ============================================================================
// uart_rx_sipo
// ----------------------------------------------------------------------------
// Serial-in/parallel-out UART receiver (8N1, LSB first, idle high) with an
// internal 32-bit word FIFO. It sits downstream of the TX serializer. It
// oversamples serial_in at tx_clk_in, recovers bytes, and queues them for the
// host. It also returns almost-full backpressure to the transmitter.
//
// Optional build macro:
//   RX_PACK32_EN  - when defined, four valid bytes are packed little-endian
//                   into one FIFO word. When undefined (default), each byte
//                   is written as {24'h0, byte}.
//
// Ports:
//   tx_clk_in         in   1   clock; single clock domain
//   rst               in   1   synchronous, active-high reset
//   serial_in         in   1   UART line, asynchronous to tx_clk_in
//   rd_en             in   1   host read strobe; ignored while empty
//   dout              out 32   FIFO read data, registered, 1-cycle latency
//   empty             out  1   FIFO empty
//   rx_fifo_full_out  out  1   almost-full (count >= DEPTH-2) to TX
//   frame_err         out  1   one-cycle pulse on a bad stop bit
//   overflow          out  1   sticky; a received word was dropped
// ============================================================================
module uart_rx_sipo #(
    parameter int CLOCK_FREQ = 200000000,
    parameter int BAUD_RATE  = 1000000,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic        tx_clk_in,
    input  logic        rst,
    input  logic        serial_in,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic        empty,
    output logic        rx_fifo_full_out,
    output logic        frame_err,
    output logic        overflow
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;

    localparam logic [31:0]     BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     HALF_LAST = 32'(HALF - 1);
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W + 1)'(DEPTH - 2);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------------
    // Line synchronizer. Preset to the idle level so reset never looks like a
    // start bit.
    // ------------------------------------------------------------------------
    logic sync1;
    logic rx_s;

    always_ff @(posedge tx_clk_in) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx_s  <= sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM. A valid stop bit in cycle S registers the write request.
    // The FIFO then commits it at the end of S+1, so empty falls in S+2.
    // ------------------------------------------------------------------------
    state_t      state;
    logic [31:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        wr_pend;
    logic [31:0] wr_data;

`ifdef RX_PACK32_EN
    logic [1:0]  byte_idx;
    logic [23:0] pack_lo;
`endif

    always_ff @(posedge tx_clk_in) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            wr_pend   <= 1'b0;
            wr_data   <= '0;
            frame_err <= 1'b0;
`ifdef RX_PACK32_EN
            byte_idx  <= '0;
            pack_lo   <= '0;
`endif
        end else begin
            // Write request and error flag are single-cycle pulses.
            wr_pend   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        // Mid start bit: a high level here was only a glitch.
                        if (!rx_s) begin
                            state    <= DATA;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        // LSB arrives first, so shift right from the top.
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end

                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            // Return to IDLE at mid stop bit so a back-to-back
                            // start edge is not missed.
                            state <= IDLE;
`ifdef RX_PACK32_EN
                            case (byte_idx)
                                2'd0: pack_lo[7:0]   <= shreg;
                                2'd1: pack_lo[15:8]  <= shreg;
                                2'd2: pack_lo[23:16] <= shreg;
                                default: begin
                                    wr_pend <= 1'b1;
                                    wr_data <= {shreg, pack_lo};
                                end
                            endcase
                            byte_idx <= byte_idx + 2'd1;
`else
                            wr_pend <= 1'b1;
                            wr_data <= {24'h0, shreg};
`endif
                        end else begin
                            // Bad stop bit: drop the byte and wait out any
                            // break so it cannot look like a new start bit.
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
`ifdef RX_PACK32_EN
                            byte_idx  <= '0;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------------
    logic [31:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // When the FIFO is full, a write is allowed only if a read frees the slot
    // in the same cycle.
    always_comb begin
        rd_ok     = rd_en && !empty;
        wr_ok     = wr_pend && ((count < CNT_DEPTH) || rd_en);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (!wr_ok && rd_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Storage has no reset. It is only read behind count.
    always_ff @(posedge tx_clk_in) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge tx_clk_in) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            dout             <= '0;
            empty            <= 1'b1;
            rx_fifo_full_out <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                // When the FIFO is full and a read and a write happen
                // together, both pointers address the same slot. dout takes
                // the old word before the write replaces it.
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count            <= count_nxt;
            empty            <= (count_nxt == '0);
            // The margin covers one frame already in flight, because TX only
            // looks at this flag between frames.
            rx_fifo_full_out <= (count_nxt >= CNT_AFULL);
            if (wr_pend && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
